// File: rtl/aes_tx_pkg.sv
// Shared widths and FSM state encoding for the AES result-port scheduler.
package aes_tx_pkg;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last winner wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_vld
);
    always_comb begin
        int w_idx;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_idx       = 0;
        // Walk the ring starting just after the previous winner.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last_grant) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_grant_vld && (w_idx == i) && i_req[i]) begin
                    o_grant_vld   = 1'b1;
                    o_grant_oh[i] = 1'b1;
                    o_grant_idx   = IDX_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/aes_tx_scheduler.sv
// Round-robin capture of 128-bit blocks from NUM_REQ producers, serialized as
// four 32-bit words on a valid/ready stream with source tag and last flag.
module aes_tx_scheduler
    import aes_tx_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][BLOCK_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [WORD_W-1:0]                 tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic                              tx_last,
    output logic [$clog2(NUM_REQ)-1:0]        tx_src,
    output logic                              busy
);
    localparam int SRC_W = $clog2(NUM_REQ);

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [SRC_W-1:0]    r_last_grant;
    logic [SRC_W-1:0]    r_src;
    logic [1:0]          r_word_cnt;
    logic [BLOCK_W-1:0]  r_shift;

    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [SRC_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic                w_accept;
    logic                w_hs;
    logic                w_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_grant_vld  (w_grant_vld)
    );

    assign w_accept  = (r_state == IDLE) && w_grant_vld;
    assign w_hs      = (r_state == SEND) && tx_ready;
    assign w_last    = (r_word_cnt == 2'(WORDS_PER_BLOCK - 1));
    assign req_ready = (r_state == IDLE) ? w_grant_oh : '0;

    assign tx_valid  = (r_state == SEND);
    assign tx_last   = (r_state == SEND) && w_last;
    assign busy      = (r_state == SEND);
    assign tx_src    = r_src;
    // The head word always sits at the end the serializer shifts out of.
    assign tx_data   = MSB_FIRST ? r_shift[BLOCK_W-1 -: WORD_W] : r_shift[WORD_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SEND;
            SEND:    if (w_hs && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= SRC_W'(NUM_REQ - 1);
            r_src        <= '0;
            r_word_cnt   <= '0;
            r_shift      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_idx;
            r_src        <= w_grant_idx;
            r_word_cnt   <= '0;
            r_shift      <= req_data[w_grant_idx];
        end else if (w_hs) begin
            r_word_cnt   <= r_word_cnt + 2'd1;
            if (MSB_FIRST) r_shift <= {r_shift[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
            else           r_shift <= {{WORD_W{1'b0}}, r_shift[BLOCK_W-1:WORD_W]};
        end
    end
endmodule

// File: tb/tb_aes_tx_scheduler.sv
// Bench for aes_tx_scheduler: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue-based block/word model.
module tb_aes_tx_scheduler;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0][127:0] req_data = '0;
    logic             tx_ready = 1'b0;

    logic [1:0]  rdy_m, rdy_l;
    logic [31:0] data_m, data_l;
    logic        valid_m, valid_l, last_m, last_l, busy_m, busy_l;
    logic [0:0]  src_m, src_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: held block as a queue of words still to be sent
    bit          mb = 1'b0;
    logic [31:0] qm[$];
    logic [31:0] ql[$];
    int          msrc  = 0;
    int          mlast = 1;
    logic [1:0]  exp_rdy, act_rdy_m, act_rdy_l;

    localparam logic [127:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [31:0] W_M [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    logic [31:0] W_L [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};

    always #5 clk = ~clk;

    aes_tx_scheduler #(.NUM_REQ(2), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_m), .tx_data(data_m), .tx_valid(valid_m), .tx_ready(tx_ready),
        .tx_last(last_m), .tx_src(src_m), .busy(busy_m));

    aes_tx_scheduler #(.NUM_REQ(2), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_l), .tx_data(data_l), .tx_valid(valid_l), .tx_ready(tx_ready),
        .tx_last(last_l), .tx_src(src_l), .busy(busy_l));

    wire [35:0] act_m = {valid_m, last_m, busy_m, src_m, data_m};
    wire [35:0] act_l = {valid_l, last_l, busy_l, src_l, data_l};

    function automatic logic [35:0] exp_m();
        logic [31:0] w;
        w = '0;
        if (mb && qm.size() > 0) w = qm[0];
        return {mb, mb && (qm.size() == 1), mb, 1'(msrc), w};
    endfunction

    function automatic logic [35:0] exp_l();
        logic [31:0] w;
        w = '0;
        if (mb && ql.size() > 0) w = ql[0];
        return {mb, mb && (ql.size() == 1), mb, 1'(msrc), w};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock: sample req_ready, apply the model's rules, land on negedge.
    task automatic step();
        int g;
        logic [127:0] d;
        #1;
        act_rdy_m = rdy_m;
        act_rdy_l = rdy_l;
        exp_rdy   = '0;
        g         = -1;
        if (!mb) begin
            for (int k = 1; k <= 2; k++) begin
                int i;
                i = (mlast + k) % 2;
                if (g < 0 && req_valid[i]) g = i;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        @(posedge clk);
        if (rst) begin
            mb = 1'b0; qm.delete(); ql.delete(); msrc = 0; mlast = 1;
        end else if (mb) begin
            if (tx_ready) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                if (qm.size() == 0) mb = 1'b0;
            end
        end else if (g >= 0) begin
            d = req_data[g];
            for (int j = 0; j < 4; j++) begin
                qm.push_back(d[127-32*j -: 32]);
                ql.push_back(d[32*j +: 32]);
            end
            msrc = g; mlast = g; mb = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; tx_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (act_m !== 36'h0 || act_l !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h want 0", act_m, act_l);
        end
        step();
        n_checks++;
        if (act_rdy_m !== 2'b00 || act_rdy_l !== 2'b00 || busy_m !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b busy=%b want 00 busy=0", act_rdy_m, act_rdy_l, busy_m);
        end
    endtask

    task automatic test_single();
        logic [31:0] om [4];
        logic [31:0] ol [4];
        logic [3:0]  ov, olast;
        req_data[0] = BLK; req_data[1] = rnd128();
        req_valid = 2'b01; tx_ready = 1'b1;
        step();
        req_valid = 2'b00;
        n_checks++;
        if (act_rdy_m !== 2'b01 || act_rdy_l !== 2'b01) begin
            n_fail++;
            $display("FAIL single_accept: req_ready %b/%b want 01", act_rdy_m, act_rdy_l);
        end
        for (int k = 0; k < 4; k++) begin
            req_data[0] = rnd128();
            om[k] = data_m; ol[k] = data_l; ov[k] = valid_m; olast[k] = last_m;
            n_checks++;
            if (act_m !== exp_m() || act_l !== exp_l() || src_m !== 1'b0) begin
                n_fail++;
                $display("FAIL single_cycle%0d: got %h/%h want %h/%h", k, act_m, act_l, exp_m(), exp_l());
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (om[k] !== W_M[k] || ol[k] !== W_L[k] || ov[k] !== 1'b1 || olast[k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_word%0d: got %h/%h v=%b last=%b want %h/%h last=%0d",
                         k, om[k], ol[k], ov[k], olast[k], W_M[k], W_L[k], (k == 3));
            end
        end
        n_checks++;
        if (busy_m !== 1'b0 || valid_m !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b valid=%b want 0 0", busy_m, valid_m);
        end
    endtask

    task automatic test_backpressure();
        req_data[0] = BLK; req_valid = 2'b01; tx_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (data_m !== 32'h44556677 || last_m !== 1'b0 || valid_m !== 1'b1 ||
                act_m !== exp_m() || act_l !== exp_l()) begin
                n_fail++;
                $display("FAIL bp_hold%0d: data=%h last=%b valid=%b want 44556677 0 1", k, data_m, last_m, valid_m);
            end
            if (k < 3) step();
        end
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (act_m !== exp_m() || act_l !== exp_l() || busy_m !== 1'b1 || data_m !== W_M[k+1]) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h busy=%b want %h busy=1", k + 1, data_m, busy_m, W_M[k+1]);
            end
            step();
        end
        n_checks++;
        if (busy_m !== 1'b0 || valid_m !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: busy=%b valid=%b want 0 0", busy_m, valid_m);
        end
    endtask

    task automatic test_fairness();
        int grants[$];
        req_valid = 2'b11;
        for (int c = 0; c < 60; c++) begin
            req_data[0] = rnd128(); req_data[1] = rnd128();
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
            if (act_rdy_m == 2'b01) grants.push_back(0);
            if (act_rdy_m == 2'b10) grants.push_back(1);
            n_checks++;
            if (act_m !== exp_m() || act_l !== exp_l() || act_rdy_m !== exp_rdy || act_rdy_l !== exp_rdy) begin
                n_fail++;
                $display("FAIL fair_cycle%0d: out %h/%h want %h/%h rdy %b want %b",
                         c, act_m, act_l, exp_m(), exp_l(), act_rdy_m, exp_rdy);
            end
        end
        n_checks++;
        if (grants.size() < 4) begin
            n_fail++;
            $display("FAIL fair_count: got %0d grants want >=4", grants.size());
        end
        // Previous block came from producer 0, so producer 1 leads the rotation.
        foreach (grants[i]) begin
            n_checks++;
            if (grants[i] != (1 + i) % 2) begin
                n_fail++;
                $display("FAIL fair_order%0d: got %0d want %0d", i, grants[i], (1 + i) % 2);
            end
        end
        req_valid = 2'b00; tx_ready = 1'b1;
        for (int c = 0; c < 8 && mb; c++) step();
        n_checks++;
        if (mb || busy_m !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_drain: busy=%b want 0", busy_m);
        end
    endtask

    task automatic test_reset_mid();
        req_data[0] = rnd128(); req_valid = 2'b01; tx_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (valid_m !== 1'b0 || busy_m !== 1'b0 || valid_l !== 1'b0 || act_m !== exp_m()) begin
            n_fail++;
            $display("FAIL rstmid_idle: valid=%b busy=%b want 0 0", valid_m, busy_m);
        end
        req_valid = 2'b11;
        step();
        n_checks++;
        if (act_rdy_m !== 2'b01 || act_rdy_l !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_grant: req_ready %b/%b want 01", act_rdy_m, act_rdy_l);
        end
        req_valid = 2'b00;
        for (int c = 0; c < 8 && mb; c++) begin
            n_checks++;
            if (act_m !== exp_m() || act_l !== exp_l()) begin
                n_fail++;
                $display("FAIL rstmid_block: got %h want %h", act_m, exp_m());
            end
            step();
        end
    endtask

    task automatic test_withdrawn();
        req_data[0] = rnd128(); req_valid = 2'b01; tx_ready = 1'b1;
        step();
        req_valid = 2'b10; req_data[1] = rnd128();
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 8 && mb; c++) begin
            n_checks++;
            if (act_rdy_m !== 2'b00 || act_m !== exp_m() || src_m !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_send%0d: rdy=%b src=%b got %h want 00 0 %h", c, act_rdy_m, src_m, act_m, exp_m());
            end
            step();
        end
        req_valid = 2'b11;
        step();
        n_checks++;
        if (act_rdy_m !== 2'b10 || act_rdy_l !== 2'b10) begin
            n_fail++;
            $display("FAIL wd_next_grant: req_ready %b/%b want 10", act_rdy_m, act_rdy_l);
        end
        req_valid = 2'b00;
        for (int c = 0; c < 8 && mb; c++) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 2'($urandom_range(0, 3));
            tx_ready  = ($urandom_range(0, 2) != 0);
            req_data[0] = rnd128(); req_data[1] = rnd128();
            step();
            n_checks++;
            if (act_m !== exp_m() || act_l !== exp_l() || act_rdy_m !== exp_rdy || act_rdy_l !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: out %h/%h want %h/%h rdy %b/%b want %b",
                         c, act_m, act_l, exp_m(), exp_l(), act_rdy_m, act_rdy_l, exp_rdy);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_withdrawn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
